rv32_encoder: RTL and testbench
===============================

// Module: rv32_encoder
// PURPOSE
// - Packs RV32I instruction fields (opcode, rd, rs1, rs2, funct3, funct7, immediate) into 32-bit instruction words.
// - Feeds the instruction-memory loader and test-program generators. It is the inverse of the core decoder path.
// - Field input uses a valid/ready handshake. Output words are buffered in a FIFO and each carries its target word address.
// - Illegal field combinations are flagged, and a canonical NOP is substituted for the bad word.
// PARAMETERS
// - ADDR_W      32  width of the target byte-address counter
// - FIFO_DEPTH  2   output queue depth in entries; must be a power of two, >= 2
// - ERR_CNT_W   8   width of the saturating error counter
// PORTS
// - clk        in   1          single clock; all state updates on posedge
// - reset      in   1          synchronous, active-high
// - in_valid   in   1          field bundle valid
// - in_ready   out  1          block can accept a bundle this cycle
// - in_opcode  in   7          major opcode, encoded with the `INST_* macros from DEFINITIONS.v
// - in_rd      in   5          destination register
// - in_rs1     in   5          source register 1
// - in_rs2     in   5          source register 2
// - in_funct3  in   3          funct3
// - in_funct7  in   7          funct7 (R-type and shifts only)
// - in_imm     in   32         immediate, given as the full signed byte value, not pre-shifted
// - load_base  in   1          load base_addr into the address counter
// - base_addr  in   ADDR_W     new base byte address
// - out_valid  out  1          FIFO head valid
// - out_ready  in   1          consumer accepts the head
// - out_instr  out  32         encoded word
// - out_addr   out  ADDR_W     byte address assigned to out_instr
// - out_err    out  1          head word was illegal; out_instr = 32'h0000_0013
// - err_count  out  ERR_CNT_W  saturating count of illegal bundles
// BEHAVIOUR
// - Reset values:
//   - in_ready=1, out_valid=0, out_instr=0, out_addr=0, out_err=0, err_count=0.
//   - Address counter=0, FIFO empty.
//   - Reset mid-operation discards all queued words.
// - Outputs never carry x or z.
// - Handshakes:
//   - Push on in_valid&in_ready.
//   - Pop on out_valid&out_ready.
//   - in_ready = (count < FIFO_DEPTH) and is registered-count based. There is no full-queue pass-through.
//   - Latency: a bundle pushed in cycle N is visible at the head in cycle N+1 if the queue was empty. Words leave in order.
//   - Simultaneous push and pop at 0 < count < FIFO_DEPTH leaves count unchanged.
//   - out_* hold stable while out_valid & !out_ready.
// - Encoding (combinational at push, stored in FIFO):
//   - R: {f7,rs2,rs1,f3,rd,op}
//   - I (ALU, LOAD, JALR, SYSTEM/CSR, FENCE): {imm[11:0],rs1,f3,rd,op}
//   - Shift (op=`INST_I_ALU, f3=001/101): {f7,imm[4:0],rs1,f3,rd,op}
//   - S: {imm[11:5],rs2,rs1,f3,imm[4:0],op}
//   - B: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}
//   - U (LUI, AUIPC): {imm[31:12],rd,op}
//   - J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}
// - Illegal bundle -> NOP 32'h0000_0013 with err=1, err_count+1 (saturates at all-ones). An illegal bundle is any of:
//   - unknown opcode
//   - I or S imm outside [-2048, 2047]
//   - B imm outside the 13-bit signed range, or imm[0]=1
//   - J imm outside the 21-bit signed range, or imm[0]=1
//   - U imm[11:0] != 0
//   - shift imm[31:5] != 0
//   - shift with f7 not 0x00 or 0x20 (0x20 is allowed only for f3=101)
// - Address counter:
//   - Each push stores the current counter into the entry, then the counter advances by 4.
//   - Wraps modulo 2^ADDR_W with no flag.
//   - load_base alone: counter <= base_addr.
//   - load_base with a push in the same cycle: the pushed word takes base_addr and the counter becomes base_addr+4.
//   - load_base does not alter words already queued.
// - Illegal words still consume an address, so the memory image stays contiguous.
// STRUCTURE
// - Shared package/include: opcode macros, funct3 codes, NOP constant, format enum {R,I,SH,S,B,U,J,BAD}.
// - Sub-module rv32_field_packer is combinational: fields in -> {instr, err}.
// - Top level holds the FIFO (pointers + count), the address counter and err_count.
// TESTING
// - addi x1,x0,5 (op 0010011, rd=1, f3=0, imm=5) -> out_instr 32'h0050_0093, err=0, addr=base.
// - sw x2,8(x1) -> 32'h0020_A423; beq x1,x2,-4 -> 32'h FE20_8EE3; lui x5 imm=32'h1234_5000 -> 32'h1234_52B7.
// - jal imm=3 -> out_instr 32'h0000_0013, out_err=1, err_count=1, address still advances by 4.
// - base=32'h100, out_ready=0, push 3 bundles -> in_ready=0 after 2.
//   - Release out_ready -> addrs 0x100, 0x104, 0x108 in order, no loss.
// - Counter at 32'hFFFF_FFFC, push 2 -> addrs FFFF_FFFC then 0000_0000.
//   - load_base with push -> word at base_addr.
// - Reset asserted with 2 queued -> next cycle out_valid=0, in_ready=1, err_count=0, counter=0.

Source files
------------

// File: rtl/rv32_encoder_pkg.sv
// Shared RV32I encoder definitions: major opcodes, funct codes, NOP word and
// the instruction-format classification used by the field packer.
package rv32_encoder_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_R_ALU  = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [6:0] F7_ZERO    = 7'h00;
  localparam logic [6:0] F7_ALT     = 7'h20;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
  } fmt_e;

  function automatic fmt_e decode_fmt(input logic [6:0] op, input logic [2:0] f3);
    fmt_e fmt;
    case (op)
      OP_R_ALU:                               fmt = FMT_R;
      OP_I_ALU:                               fmt = (f3 == F3_SLL || f3 == F3_SRL_SRA) ? FMT_SH : FMT_I;
      OP_LOAD, OP_JALR, OP_SYSTEM, OP_FENCE:  fmt = FMT_I;
      OP_STORE:                               fmt = FMT_S;
      OP_BRANCH:                              fmt = FMT_B;
      OP_LUI, OP_AUIPC:                       fmt = FMT_U;
      OP_JAL:                                 fmt = FMT_J;
      default:                                fmt = FMT_BAD;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/rv32_field_packer.sv
// Combinational RV32I field packer: places fields into the instruction word
// and flags bundles that have no legal encoding (word replaced by NOP).
module rv32_field_packer
  import rv32_encoder_pkg::*;
(
  input  logic [6:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  f3,
  input  logic [6:0]  f7,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        err
);

  fmt_e               fmt;
  logic signed [31:0] imm_s;
  logic               fits_12, fits_13, fits_21, shamt_ok, f7_ok;
  logic [31:0]        word;
  logic               bad;

  assign fmt   = decode_fmt(op, f3);
  assign imm_s = imm;

  assign fits_12  = (imm_s >= -32'sd2048)    && (imm_s <= 32'sd2047);
  assign fits_13  = (imm_s >= -32'sd4096)    && (imm_s <= 32'sd4095);
  assign fits_21  = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048575);
  assign shamt_ok = (imm[31:5] == '0);
  // SRA/SRAI is the only shift that may carry funct7 = 0x20
  assign f7_ok    = (f7 == F7_ZERO) || ((f7 == F7_ALT) && (f3 == F3_SRL_SRA));

  always_comb begin
    word = NOP_INSTR;
    bad  = 1'b0;
    case (fmt)
      FMT_R:  word = {f7, rs2, rs1, f3, rd, op};
      FMT_I:  begin word = {imm[11:0], rs1, f3, rd, op};                                    bad = !fits_12;           end
      FMT_SH: begin word = {f7, imm[4:0], rs1, f3, rd, op};                                 bad = !shamt_ok || !f7_ok; end
      FMT_S:  begin word = {imm[11:5], rs2, rs1, f3, imm[4:0], op};                         bad = !fits_12;           end
      FMT_B:  begin word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};       bad = !fits_13 || imm[0]; end
      FMT_U:  begin word = {imm[31:12], rd, op};                                            bad = (imm[11:0] != '0);  end
      FMT_J:  begin word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};               bad = !fits_21 || imm[0]; end
      default: bad = 1'b1;
    endcase
    instr = bad ? NOP_INSTR : word;
    err   = bad;
  end

endmodule

// File: rtl/rv32_encoder.sv
// RV32I encoder top: valid/ready field input, packed words queued with their
// target byte address, saturating count of illegal bundles.
module rv32_encoder
  import rv32_encoder_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [6:0]           in_opcode,
  input  logic [4:0]           in_rd,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [2:0]           in_funct3,
  input  logic [6:0]           in_funct7,
  input  logic [31:0]          in_imm,
  input  logic                 load_base,
  input  logic [ADDR_W-1:0]    base_addr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic [ADDR_W-1:0]    out_addr,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int              PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]  DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [31:0]       pk_instr;
  logic              pk_err;
  logic [31:0]       instr_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] addr_q  [FIFO_DEPTH];
  logic              err_q   [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;
  logic [ADDR_W-1:0] addr_cnt, push_addr;
  logic              push, pop;

  rv32_field_packer u_packer (
    .op    (in_opcode),
    .rd    (in_rd),
    .rs1   (in_rs1),
    .rs2   (in_rs2),
    .f3    (in_funct3),
    .f7    (in_funct7),
    .imm   (in_imm),
    .instr (pk_instr),
    .err   (pk_err)
  );

  assign in_ready  = (count < DEPTH_C);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  // A same-cycle load_base redirects the word being pushed
  assign push_addr = load_base ? base_addr : addr_cnt;

  // Empty queue presents zeros so stale storage never reaches the outputs
  assign out_instr = out_valid ? instr_q[rd_ptr] : '0;
  assign out_addr  = out_valid ? addr_q[rd_ptr]  : '0;
  assign out_err   = out_valid ? err_q[rd_ptr]   : 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      addr_cnt  <= '0;
      err_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (push)           addr_cnt <= push_addr + ADDR_W'(4);
      else if (load_base) addr_cnt <= base_addr;
      if (push && pk_err) err_count <= sat_inc(err_count);
    end
  end

  // Queue storage is data only; occupancy is governed by the pointers above
  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[wr_ptr] <= pk_instr;
      addr_q[wr_ptr]  <= push_addr;
      err_q[wr_ptr]   <= pk_err;
    end
  end

endmodule

// File: tb/tb_rv32_encoder.sv
// Bench for rv32_encoder: directed encodings, backpressure, address wrap,
// randomized traffic against a reference model, saturation and reset.
module tb_rv32_encoder;

  localparam logic [6:0] T_LUI = 7'b0110111, T_AUIPC = 7'b0010111, T_JAL = 7'b1101111;
  localparam logic [6:0] T_JALR = 7'b1100111, T_BR = 7'b1100011, T_LOAD = 7'b0000011;
  localparam logic [6:0] T_STORE = 7'b0100011, T_IALU = 7'b0010011, T_R = 7'b0110011;
  localparam logic [6:0] T_FENCE = 7'b0001111, T_SYS = 7'b1110011;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, load_base, out_valid, out_ready, out_err;
  logic [6:0]  in_opcode, in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [31:0] in_imm, base_addr, out_instr, out_addr;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  rv32_encoder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .load_base(load_base), .base_addr(base_addr), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .out_err(out_err), .err_count(err_count)
  );

  typedef struct { logic [31:0] instr; logic err; logic [31:0] addr; } exp_t;
  exp_t        sb[$];
  int          n_chk = 0, n_pass = 0;
  int          mdl_err = 0;
  logic [31:0] mdl_addr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_head(input string tag, input logic [31:0] ins, input logic e, input logic [31:0] a);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_instr"}, out_instr, ins);
    chk({tag, "_err"}, 32'(out_err), 32'(e));
    chk({tag, "_addr"}, out_addr, a);
  endtask

  // Reference: word built by arithmetic bit placement from the format rules
  function automatic void model(input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                                input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                                output logic [31:0] w, output logic e);
    longint      s  = longint'($signed(imm));
    logic [31:0] u  = imm;
    logic [31:0] b  = 32'(op) | (32'(rd) << 7);
    logic [31:0] rr = (32'(f3) << 12) | (32'(rs1) << 15);
    e = 1'b0;
    w = 32'h0;
    case (op)
      T_R: w = b | rr | (32'(rs2) << 20) | (32'(f7) << 25);
      T_IALU, T_LOAD, T_JALR, T_SYS, T_FENCE:
        if (op == T_IALU && (f3 == 3'd1 || f3 == 3'd5)) begin
          w = b | rr | ((u & 31) << 20) | (32'(f7) << 25);
          e = (u > 31) || !(f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'd5));
        end else begin
          w = b | rr | ((u & 32'hFFF) << 20);
          e = (s < -2048) || (s > 2047);
        end
      T_STORE: begin
        w = 32'(op) | ((u & 31) << 7) | rr | (32'(rs2) << 20) | (((u >> 5) & 127) << 25);
        e = (s < -2048) || (s > 2047);
      end
      T_BR: begin
        w = 32'(op) | (((u >> 11) & 1) << 7) | (((u >> 1) & 15) << 8) | rr | (32'(rs2) << 20)
            | (((u >> 5) & 63) << 25) | (((u >> 12) & 1) << 31);
        e = (s < -4096) || (s > 4095) || (u % 2 != 0);
      end
      T_LUI, T_AUIPC: begin
        w = b | (u & 32'hFFFF_F000);
        e = (u % 4096) != 0;
      end
      T_JAL: begin
        w = b | (((u >> 12) & 255) << 12) | (((u >> 11) & 1) << 20) | (((u >> 1) & 1023) << 21)
            | (((u >> 20) & 1) << 31);
        e = (s < -1048576) || (s > 1048575) || (u % 2 != 0);
      end
      default: e = 1'b1;
    endcase
    if (e) w = 32'h0000_0013;
  endfunction

  task automatic send(input logic [6:0] op, input logic [4:0] rd, rs1, rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm, input logic lb);
    logic [31:0] w;
    logic        e;
    in_valid = 1'b1; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; load_base = lb;
    model(op, rd, rs1, rs2, f3, f7, imm, w, e);
    if (e && mdl_err < 255) mdl_err++;
    @(posedge clk); #1;
    in_valid = 1'b0; load_base = 1'b0;
  endtask

  task automatic load_only(input logic [31:0] a);
    base_addr = a; load_base = 1'b1;
    @(posedge clk); #1;
    load_base = 1'b0;
  endtask

  task automatic rand_fields();
    logic [6:0] ops [12];
    ops = '{T_LUI, T_AUIPC, T_JAL, T_JALR, T_BR, T_LOAD, T_STORE, T_IALU, T_R, T_FENCE, T_SYS, 7'b1111111};
    in_opcode = ops[$urandom_range(0, 11)];
    if ($urandom_range(0, 2) == 0) in_opcode = T_IALU;
    in_rd = 5'($urandom); in_rs1 = 5'($urandom); in_rs2 = 5'($urandom);
    in_funct3 = 3'($urandom);
    case ($urandom_range(0, 2))
      0:       in_funct7 = 7'h00;
      1:       in_funct7 = 7'h20;
      default: in_funct7 = 7'($urandom);
    endcase
    case ($urandom_range(0, 5))
      0:       in_imm = $urandom;
      1:       in_imm = 32'(int'($urandom_range(0, 4095)) - 2048);
      2:       in_imm = 32'(int'($urandom_range(0, 8191)) - 4096) & ~32'd1;
      3:       in_imm = 32'(int'($urandom_range(0, 2097151)) - 1048576) & ~32'd1;
      4:       in_imm = $urandom & 32'hFFFF_F000;
      default: in_imm = 32'($urandom_range(0, 40));
    endcase
  endtask

  initial begin
    reset = 1'b1; in_valid = 0; load_base = 0; out_ready = 1'b1; base_addr = 0;
    in_opcode = 0; in_rd = 0; in_rs1 = 0; in_rs2 = 0; in_funct3 = 0; in_funct7 = 0; in_imm = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_addr", out_addr, 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // directed encodings from base 0x40
    load_only(32'h40);
    send(T_IALU, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0);
    chk_head("addi", 32'h0050_0093, 1'b0, 32'h40);
    send(T_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b0);
    chk_head("sw", 32'h0020_A423, 1'b0, 32'h44);
    send(T_BR, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd4, 1'b0);
    chk_head("beq", 32'hFE20_8EE3, 1'b0, 32'h48);
    send(T_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 1'b0);
    chk_head("lui", 32'h1234_52B7, 1'b0, 32'h4C);
    send(T_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 1'b0);
    chk_head("jal_odd", 32'h0000_0013, 1'b1, 32'h50);
    chk("jal_err_count", 32'(err_count), 32'd1);
    send(T_IALU, 5'd3, 5'd4, 5'd0, 3'd5, 7'h20, 32'd7, 1'b0);
    chk_head("srai", 32'h4072_5193, 1'b0, 32'h54);
    send(T_IALU, 5'd3, 5'd4, 5'd0, 3'd1, 7'h20, 32'd7, 1'b0);
    chk_head("slli_f7", 32'h0000_0013, 1'b1, 32'h58);

    // backpressure: two entries fill the queue, third waits for a pop
    load_only(32'h100);
    out_ready = 1'b0;
    in_valid = 1'b1; in_opcode = T_IALU; in_rd = 5'd1; in_rs1 = 0; in_rs2 = 0;
    in_funct3 = 0; in_funct7 = 0; in_imm = 32'd1;
    @(posedge clk); #1;
    chk("bp_ready_1", 32'(in_ready), 32'd1);
    in_imm = 32'd2;
    @(posedge clk); #1;
    chk("bp_ready_full", 32'(in_ready), 32'd0);
    in_imm = 32'd3;
    @(posedge clk); #1;
    chk("bp_ready_held", 32'(in_ready), 32'd0);
    chk_head("bp_hold", 32'h0010_0093, 1'b0, 32'h100);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk_head("bp_b", 32'h0020_0093, 1'b0, 32'h104);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk_head("bp_c", 32'h0030_0093, 1'b0, 32'h108);
    @(posedge clk); #1;
    chk("bp_empty", 32'(out_valid), 32'd0);

    // address wrap and load_base coinciding with a push
    load_only(32'hFFFF_FFFC);
    send(T_IALU, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0);
    chk_head("wrap_a", 32'h0050_0093, 1'b0, 32'hFFFF_FFFC);
    send(T_IALU, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0);
    chk_head("wrap_b", 32'h0050_0093, 1'b0, 32'h0);
    base_addr = 32'h2000;
    send(T_IALU, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1);
    chk_head("lb_push", 32'h0050_0093, 1'b0, 32'h2000);
    send(T_IALU, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0);
    chk_head("lb_next", 32'h0050_0093, 1'b0, 32'h2004);
    @(posedge clk); #1;

    // randomized traffic against the scoreboard
    mdl_addr = $urandom & ~32'd3;
    load_only(mdl_addr);
    for (int cyc = 0; cyc < 500; cyc++) begin
      int          occ;
      logic [31:0] w, a;
      logic        e;
      occ = sb.size();
      chk("rnd_in_ready", 32'(in_ready), 32'(occ < 2));
      chk("rnd_out_valid", 32'(out_valid), 32'(occ > 0));
      chk("rnd_err_count", 32'(err_count), 32'(mdl_err));
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      load_base = ($urandom_range(0, 15) == 0);
      base_addr = $urandom & ~32'd3;
      rand_fields();
      if (occ > 0) begin
        chk("rnd_instr", out_instr, sb[0].instr);
        chk("rnd_err", 32'(out_err), 32'(sb[0].err));
        chk("rnd_addr", out_addr, sb[0].addr);
        if (out_ready) void'(sb.pop_front());
      end
      if (in_valid && occ < 2) begin
        model(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, w, e);
        a = load_base ? base_addr : mdl_addr;
        sb.push_back('{w, e, a});
        mdl_addr = a + 32'd4;
        if (e && mdl_err < 255) mdl_err++;
      end else if (load_base) begin
        mdl_addr = base_addr;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; load_base = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rnd_drained", 32'(out_valid), 32'd0);

    // error counter saturation
    in_valid = 1'b1; in_opcode = T_JAL; in_imm = 32'd1;
    repeat (260) @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("sat_err_count", 32'(err_count), 32'd255);

    // reset with two queued words
    out_ready = 1'b0;
    send(T_IALU, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0);
    send(T_IALU, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6, 1'b0);
    chk("pre_rst_full", 32'(in_ready), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_err_count", 32'(err_count), 32'd0);
    chk("mid_rst_out_instr", out_instr, 32'd0);
    out_ready = 1'b1;
    send(T_IALU, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0);
    chk_head("post_rst", 32'h0050_0093, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
